// File: rtl/axil_pkg.sv
// Shared AXI4-Lite responder definitions: response codes and the read-side state encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RESP
    } rd_state_e;

endpackage

// File: rtl/axil_addr_check.sv
// Combinational AXI4-Lite address classifier, shared by the read and write responders.
module axil_addr_check
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_REGS     = 16,
    parameter bit REQUIRE_PRIV = 1'b0,
    parameter int IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]            prot_i,
    output logic                  err_o,
    output logic [1:0]            resp_o,
    output logic [IDX_W-1:0]      idx_o
);

    localparam logic [ADDR_WIDTH-3:0] NUM_REGS_W = (ADDR_WIDTH-2)'(NUM_REGS);

    logic                  misaligned;
    logic                  unpriv;
    logic                  out_of_range;
    logic                  unused_prot;
    logic [ADDR_WIDTH-3:0] word;

    assign word         = addr_i[ADDR_WIDTH-1:2];
    assign misaligned   = (addr_i[1:0] != 2'b00);
    assign unpriv       = REQUIRE_PRIV && !prot_i[0];
    // Any set bit above the register window lands here, not just the index bits.
    assign out_of_range = (word >= NUM_REGS_W);
    assign unused_prot  = ^prot_i[2:1];
    assign idx_o        = addr_i[IDX_W+1:2];

    always_comb begin
        err_o  = 1'b1;
        resp_o = RESP_SLVERR;
        if (misaligned || unpriv) begin
            resp_o = RESP_SLVERR;
        end else if (out_of_range) begin
            resp_o = RESP_DECERR;
        end else begin
            err_o  = 1'b0;
            resp_o = RESP_OKAY;
        end
    end

endmodule

// File: rtl/axil_read_responder.sv
// AXI4-Lite read responder: one outstanding AR, fetch from a synchronous register bank,
// return on R with full backpressure and a saturating error counter.
module axil_read_responder
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 16,
    parameter int READ_LATENCY = 1,
    parameter bit REQUIRE_PRIV = 1'b0,
    parameter int IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [2:0]            ARPROT,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  reg_rd_en,
    output logic [IDX_W-1:0]      reg_rd_idx,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic [15:0]           err_count
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    rd_state_e             state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [15:0]           errcnt_q, errcnt_d;
    logic                  live_q;

    logic                  chk_err;
    logic [1:0]            chk_resp;
    logic [IDX_W-1:0]      chk_idx;

    axil_addr_check #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_REGS    (NUM_REGS),
        .REQUIRE_PRIV(REQUIRE_PRIV),
        .IDX_W       (IDX_W)
    ) u_addr_check (
        .addr_i(ARADDR),
        .prot_i(ARPROT),
        .err_o (chk_err),
        .resp_o(chk_resp),
        .idx_o (chk_idx)
    );

    // live_q holds ARREADY low for the cycle right after reset is released.
    assign ARREADY    = (state_q == ST_IDLE) && live_q;
    assign RVALID     = (state_q == ST_RESP);
    assign RDATA      = rdata_q;
    assign RRESP      = rresp_q;
    assign reg_rd_en  = (state_q == ST_FETCH) && (cnt_q == 3'd1);
    assign reg_rd_idx = idx_q;
    assign err_count  = errcnt_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        errcnt_d = errcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ARVALID && ARREADY) begin
                    idx_d = chk_idx;
                    if (chk_err) begin
                        state_d = ST_RESP;
                        rresp_d = chk_resp;
                        rdata_d = '0;
                        if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
                    end else begin
                        state_d = ST_FETCH;
                        rresp_d = RESP_OKAY;
                        cnt_d   = 3'd1;
                    end
                end
            end
            ST_FETCH: begin
                if (cnt_q == LAT) begin
                    state_d = ST_RESP;
                    rdata_d = reg_rd_data;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (RREADY) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    rresp_d = RESP_OKAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            idx_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            errcnt_q <= 16'd0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            errcnt_q <= errcnt_d;
            live_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axil_read_responder.sv
// Randomized bench for axil_read_responder (READ_LATENCY=3, REQUIRE_PRIV=1) against a
// transaction-level model of response code, data, latency and error count.
module tb_axil_read_responder;
    import axil_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int NREGS = 16;
    localparam int RL    = 3;
    localparam bit PRIV  = 1'b1;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [AW-1:0] ARADDR = '0;
    logic [2:0]    ARPROT = '0;
    logic          RVALID;
    logic          RREADY = 1'b0;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          reg_rd_en;
    logic [3:0]    reg_rd_idx;
    logic [DW-1:0] reg_rd_data;
    logic [15:0]   err_count;

    int            cyc = 0;
    int            hs_cyc = 0;
    int            n_cmp = 0;
    int            n_mis = 0;
    logic [15:0]   err_model = '0;
    logic [DW-1:0] bank [NREGS];
    logic [3:0]    en_hist = '0;

    axil_read_responder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NREGS),
        .READ_LATENCY(RL),
        .REQUIRE_PRIV(PRIV)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .ARADDR     (ARADDR),
        .ARPROT     (ARPROT),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .reg_rd_en  (reg_rd_en),
        .reg_rd_idx (reg_rd_idx),
        .reg_rd_data(reg_rd_data),
        .err_count  (err_count)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Bank model: word is only valid RL-1 cycles after the strobe, garbage otherwise.
    always @(posedge ACLK) en_hist <= {en_hist[2:0], reg_rd_en};
    always_comb reg_rd_data = en_hist[RL-2] ? bank[reg_rd_idx] : (32'hA5A5_0000 ^ 32'(cyc));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] p);
        if (a % 4 != 0)             return RESP_SLVERR;
        if (PRIV && p[0] == 1'b0)   return RESP_SLVERR;
        if (a / 4 >= NREGS)         return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    // Entered and left at a negedge while the DUT is idle.
    task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int wait_n);
        logic [1:0]  er;
        logic [31:0] ed;
        int          first;
        int          en_cnt;
        er = exp_resp(a, p);
        ed = (er == RESP_OKAY) ? bank[a[5:2]] : '0;
        if (er != RESP_OKAY && err_model != 16'hFFFF) err_model++;
        chk("arready_idle", 32'(ARREADY), 1);
        ARVALID = 1'b1; ARADDR = a; ARPROT = p; RREADY = (wait_n == 0);
        hs_cyc = cyc;
        first = 0;
        en_cnt = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            @(negedge ACLK);
            if (k == 1) chk("errcnt_at_ar", 32'(err_count), 32'(err_model));
            if (reg_rd_en) begin
                en_cnt++;
                chk("rd_en_cycle", 32'(k), 1);
                chk("rd_idx", 32'(reg_rd_idx), 32'(a[5:2]));
            end
            chk("arready_busy", 32'(ARREADY), 0);
            if (RVALID) first = k;
            else begin
                ARVALID = 1'($urandom_range(0, 1));
                ARADDR  = $urandom;
            end
        end
        chk("rd_en_count", 32'(en_cnt), (er == RESP_OKAY) ? 1 : 0);
        if (first == 0) begin
            chk("rvalid_timeout", 32'(RVALID), 1);
            ARVALID = 1'b0;
            RREADY  = 1'b1;
            repeat (4) @(negedge ACLK);
            RREADY  = 1'b0;
            return;
        end
        chk("rvalid_lat", 32'(first), (er == RESP_OKAY) ? RL + 1 : 1);
        for (int g = 0; g <= wait_n; g++) begin
            chk("rvalid_hold", 32'(RVALID), 1);
            chk("rdata", RDATA, ed);
            chk("rresp", 32'(RRESP), 32'(er));
            chk("arready_resp", 32'(ARREADY), 0);
            if (g >= wait_n) begin
                RREADY  = 1'b1;
                ARVALID = 1'b0;
            end else begin
                ARVALID = 1'($urandom_range(0, 1));
            end
            @(negedge ACLK);
        end
        RREADY = 1'b0;
        chk("rvalid_after", 32'(RVALID), 0);
        chk("arready_after", 32'(ARREADY), 1);
        chk("rdata_idle", RDATA, 0);
    endtask

    initial begin
        int          t1;
        logic [31:0] a;
        logic [2:0]  p;
        for (int i = 0; i < NREGS; i++) bank[i] = $urandom;
        bank[3] = 32'hDEADBEEF;

        repeat (2) @(negedge ACLK);
        chk("rst_arready", 32'(ARREADY), 0);
        chk("rst_rvalid", 32'(RVALID), 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_rresp", 32'(RRESP), 0);
        chk("rst_rd_en", 32'(reg_rd_en), 0);
        chk("rst_errcnt", 32'(err_count), 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("arready_post_rst", 32'(ARREADY), 1);

        do_read(32'h0C, 3'b001, 0);
        do_read(32'h0C, 3'b001, 5);
        do_read(32'h06, 3'b001, 0);
        do_read(32'h40, 3'b001, 0);
        chk("errcnt_two", 32'(err_count), 2);
        do_read(32'h00, 3'b000, 0);
        do_read(32'h00, 3'b001, 0);
        do_read(32'h40, 3'b000, 2);
        do_read(32'h8000_000C, 3'b111, 1);

        do_read(32'h0C, 3'b001, 0);
        t1 = hs_cyc;
        do_read(32'h20, 3'b001, 0);
        chk("b2b_ok_spacing", 32'(hs_cyc - t1), RL + 2);
        do_read(32'h06, 3'b001, 0);
        t1 = hs_cyc;
        do_read(32'h10, 3'b011, 0);
        chk("b2b_err_spacing", 32'(hs_cyc - t1), 2);

        ARVALID = 1'b1; ARADDR = 32'h06; ARPROT = 3'b001; RREADY = 1'b0;
        err_model++;
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("mid_rvalid", 32'(RVALID), 1);
        chk("mid_errcnt", 32'(err_count), 32'(err_model));
        ARESETn = 1'b0;
        @(negedge ACLK);
        err_model = '0;
        chk("mid_rst_rvalid", 32'(RVALID), 0);
        chk("mid_rst_errcnt", 32'(err_count), 0);
        chk("mid_rst_arready", 32'(ARREADY), 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("mid_rst_release", 32'(ARREADY), 1);

        for (int i = 0; i < 150; i++) begin
            bank[$urandom_range(0, NREGS - 1)] = $urandom;
            a = $urandom;
            case ($urandom_range(0, 3))
                0, 1: a = {26'd0, a[5:2], 2'b00};
                2:    if (a[1:0] == 2'b00) a[0] = 1'b1;
                default: begin a[1:0] = 2'b00; a[6] = 1'b1; end
            endcase
            p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) p[0] = 1'b1;
            do_read(a, p, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
